// File: rtl/lexer.sv
// Byte-to-token front end for the LR parser.
// Classifies ASCII chars, builds numbers and queues 16-bit tokens.
module lexer #(
  parameter int          TOKQ_DEPTH = 4,
  parameter logic [7:0]  EOF_CHAR   = 8'h0A
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        I_VALID,
  input  logic [7:0]  I_CHAR,
  output logic        I_READY,
  output logic        O_VALID,
  output logic [15:0] O_TOKEN,
  input  logic        RECEIVE,
  output logic [1:0]  STAT
);

  localparam int PW = $clog2(TOKQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [15:0] T_PLUS = 16'h0100;
  localparam logic [15:0] T_STAR = 16'h0200;
  localparam logic [15:0] T_EOF  = 16'h0300;

  typedef enum logic [1:0] {
    S_IDLE, S_NUM, S_DONE, S_ERROR
  } state_t;

  state_t         state, state_nx;
  logic [7:0]     acc, acc_nx;
  logic [15:0]    q [TOKQ_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     n_push;
  logic [15:0]    tok0, tok1;
  logic           accept, pop;
  logic           is_dig, is_plus, is_star;
  logic           is_sp, is_eof;
  logic [11:0]    prod;
  logic [15:0]    op_tok, num_tok;

  assign is_dig  = (I_CHAR >= 8'h30) &&
                   (I_CHAR <= 8'h39);
  assign is_plus = (I_CHAR == 8'h2B);
  assign is_star = (I_CHAR == 8'h2A);
  assign is_sp   = (I_CHAR == 8'h20);
  assign is_eof  = (I_CHAR == EOF_CHAR) ||
                   (I_CHAR == 8'h00);

  // Wide enough that acc*10+9 never wraps.
  assign prod    = {4'b0, acc} * 12'd10 +
                   {8'b0, I_CHAR[3:0]};
  assign op_tok  = is_plus ? T_PLUS : T_STAR;
  assign num_tok = {8'h00, acc};
  assign accept  = I_VALID && I_READY;
  assign pop     = RECEIVE && (count != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    n_push   = 2'd0;
    tok0     = '0;
    tok1     = '0;
    if (accept) begin
      unique case (1'b1)
        is_dig: begin
          if (state == S_IDLE) begin
            acc_nx   = {4'b0, I_CHAR[3:0]};
            state_nx = S_NUM;
          end else if (prod > 12'd255) begin
            state_nx = S_ERROR;
          end else begin
            acc_nx = prod[7:0];
          end
        end
        is_plus, is_star: begin
          if (state == S_NUM) begin
            n_push = 2'd2;
            tok0   = num_tok;
            tok1   = op_tok;
          end else begin
            n_push = 2'd1;
            tok0   = op_tok;
          end
          state_nx = S_IDLE;
        end
        is_sp: begin
          if (state == S_NUM) begin
            n_push = 2'd1;
            tok0   = num_tok;
          end
          state_nx = S_IDLE;
        end
        is_eof: begin
          if (state == S_NUM) begin
            n_push = 2'd2;
            tok0   = num_tok;
            tok1   = T_EOF;
          end else begin
            n_push = 2'd1;
            tok0   = T_EOF;
          end
          state_nx = S_DONE;
        end
        default: state_nx = S_ERROR;
      endcase
    end
  end

  always_comb begin
    I_READY = RST_N &&
              ((state == S_IDLE) ||
               (state == S_NUM)) &&
              (count <= CW'(TOKQ_DEPTH - 2));
    O_VALID = (count != '0);
    O_TOKEN = O_VALID ? q[rd_ptr] : 16'h0000;
    STAT    = {state == S_DONE,
               state == S_ERROR};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (n_push != 2'd0)
      q[wr_ptr] <= tok0;
    if (n_push == 2'd2)
      q[wr_ptr + PW'(1)] <= tok1;
  end

endmodule
